// File: rtl/alu_seq_controller.sv
// Button-driven ALU controller: strict A -> B -> opcode load order, registered result and flags.
// Optional macro ALU_CHAIN_EN: in DONE, button 1 loads A from the last result and B from switches.
module alu_seq_controller #(
   parameter int unsigned NB_DATA      = 8,
   parameter int unsigned NB_OPCODE    = 6,
   parameter int unsigned N_PULSADORES = 3
) (
   input  logic                    i_clock,
   input  logic                    i_reset,
   input  logic [NB_DATA-1:0]      i_switches,
   input  logic [N_PULSADORES-1:0] i_pulsadores,
   output logic [NB_DATA-1:0]      o_result,
   output logic                    o_valid,
   output logic                    o_zero,
   output logic                    o_carry,
   output logic                    o_overflow,
   output logic                    o_opcode_err,
   output logic                    o_seq_err,
   output logic [2:0]              o_state
);

   localparam int unsigned Msb = NB_DATA - 1;

   localparam logic [2:0] StIdle  = 3'd0;
   localparam logic [2:0] StHaveA = 3'd1;
   localparam logic [2:0] StHaveB = 3'd2;
   localparam logic [2:0] StExec  = 3'd3;
   localparam logic [2:0] StDone  = 3'd4;

   localparam logic [NB_OPCODE-1:0] OpAdd = NB_OPCODE'(6'b100000);
   localparam logic [NB_OPCODE-1:0] OpSub = NB_OPCODE'(6'b100010);
   localparam logic [NB_OPCODE-1:0] OpAnd = NB_OPCODE'(6'b100100);
   localparam logic [NB_OPCODE-1:0] OpOr  = NB_OPCODE'(6'b100101);
   localparam logic [NB_OPCODE-1:0] OpXor = NB_OPCODE'(6'b100110);
   localparam logic [NB_OPCODE-1:0] OpNor = NB_OPCODE'(6'b100111);
   localparam logic [NB_OPCODE-1:0] OpSrl = NB_OPCODE'(6'b000010);
   localparam logic [NB_OPCODE-1:0] OpSra = NB_OPCODE'(6'b000011);

   logic [N_PULSADORES-1:0] prev_q, rise;
   logic [2:0]              state_q, state_d;
   logic [NB_DATA-1:0]      a_q, a_d, b_q, b_d;
   logic [NB_OPCODE-1:0]    op_q, op_d;
   logic                    seq_err_q, seq_err_d;
   logic [NB_DATA-1:0]      res_q;
   logic                    zero_q, carry_q, ovf_q, op_err_q;
   logic                    single_ev, multi_ev;

   logic [NB_DATA:0]        sum, diff;
   logic [NB_DATA-1:0]      alu_res;
   logic                    alu_c, alu_v, alu_e;

   assign rise      = i_pulsadores & ~prev_q;
   assign single_ev = ($countones(rise) == 1);
   assign multi_ev  = ($countones(rise) > 1);

   assign sum  = {1'b0, a_q} + {1'b0, b_q};
   assign diff = {1'b0, a_q} - {1'b0, b_q};

   // Shift operators already yield 0 / sign fill when B >= NB_DATA.
   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      alu_e   = 1'b0;
      case (op_q)
         OpAdd: begin
            alu_res = sum[Msb:0];
            alu_c   = sum[NB_DATA];
            alu_v   = (a_q[Msb] == b_q[Msb]) && (sum[Msb] != a_q[Msb]);
         end
         OpSub: begin
            alu_res = diff[Msb:0];
            alu_c   = diff[NB_DATA];
            alu_v   = (a_q[Msb] != b_q[Msb]) && (diff[Msb] != a_q[Msb]);
         end
         OpAnd:   alu_res = a_q & b_q;
         OpOr:    alu_res = a_q | b_q;
         OpXor:   alu_res = a_q ^ b_q;
         OpNor:   alu_res = ~(a_q | b_q);
         OpSrl:   alu_res = a_q >> b_q;
         OpSra:   alu_res = $unsigned($signed(a_q) >>> b_q);
         default: alu_e   = 1'b1;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      op_d      = op_q;
      seq_err_d = 1'b0;
      if (state_q == StExec) begin
         state_d   = StDone;
         seq_err_d = |rise;
      end else if (multi_ev) begin
         seq_err_d = 1'b1;
      end else if (single_ev) begin
         case (state_q)
            StIdle, StDone: begin
               if (rise[0]) begin
                  a_d     = i_switches;
                  state_d = StHaveA;
`ifdef ALU_CHAIN_EN
               end else if (rise[1] && state_q == StDone) begin
                  a_d     = res_q;
                  b_d     = i_switches;
                  state_d = StHaveB;
`endif
               end else begin
                  seq_err_d = 1'b1;
               end
            end
            StHaveA: begin
               if (rise[1]) begin
                  b_d     = i_switches;
                  state_d = StHaveB;
               end else begin
                  seq_err_d = 1'b1;
               end
            end
            StHaveB: begin
               if (rise[2]) begin
                  op_d    = i_switches[NB_OPCODE-1:0];
                  state_d = StExec;
               end else begin
                  seq_err_d = 1'b1;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // prev is sampled even in reset so a held button yields no event on release.
   always_ff @(posedge i_clock) begin
      prev_q <= i_pulsadores;
      if (!i_reset) begin
         state_q   <= StIdle;
         a_q       <= '0;
         b_q       <= '0;
         op_q      <= '0;
         seq_err_q <= 1'b0;
         res_q     <= '0;
         zero_q    <= 1'b0;
         carry_q   <= 1'b0;
         ovf_q     <= 1'b0;
         op_err_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         op_q      <= op_d;
         seq_err_q <= seq_err_d;
         if (state_q == StExec) begin
            res_q    <= alu_res;
            zero_q   <= (alu_res == '0);
            carry_q  <= alu_c;
            ovf_q    <= alu_v;
            op_err_q <= alu_e;
         end
      end
   end

   assign o_result     = res_q;
   assign o_valid      = (state_q == StDone);
   assign o_zero       = zero_q;
   assign o_carry      = carry_q;
   assign o_overflow   = ovf_q;
   assign o_opcode_err = op_err_q;
   assign o_seq_err    = seq_err_q;
   assign o_state      = state_q;

endmodule

// File: tb/tb_alu_seq_controller.sv
// Scoreboard bench for alu_seq_controller: a spec-level model predicts per-cycle state/error
// and per-operation results; a monitor compares whenever the DUT presents them.
module tb_alu_seq_controller;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] sw = '0;
   logic [2:0] btn = '0;
   logic [7:0] result;
   logic       valid, zero, carry, ovf, op_err, seq_err;
   logic [2:0] state;

   alu_seq_controller dut (
      .i_clock      (clk),
      .i_reset      (rst_n),
      .i_switches   (sw),
      .i_pulsadores (btn),
      .o_result     (result),
      .o_valid      (valid),
      .o_zero       (zero),
      .o_carry      (carry),
      .o_overflow   (ovf),
      .o_opcode_err (op_err),
      .o_seq_err    (seq_err),
      .o_state      (state)
   );

   always #5 clk = ~clk;

`ifdef ALU_CHAIN_EN
   localparam bit Chain = 1'b1;
`else
   localparam bit Chain = 1'b0;
`endif

   typedef struct {
      logic [7:0] res;
      logic       z, c, v, e;
   } res_t;
   typedef struct {
      int         cyc;
      logic       err;
      logic [2:0] st;
   } ev_t;

   res_t res_q[$];
   ev_t  ev_q[$];
   int   cyc = 0;
   int   checks = 0;
   int   passed = 0;

   // Model state: 0 IDLE, 1 HAVE_A, 2 HAVE_B, 3 EXEC, 4 DONE.
   int         mstate = 0;
   logic [7:0] ma = '0, mb = '0, mres = '0;
   logic [5:0] mop = '0;
   logic [2:0] mprev = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
   endtask

   function automatic res_t model_alu(input logic [7:0] a, input logic [7:0] b,
                                      input logic [5:0] op);
      res_t r;
      int ua, ub, sa, sb, x;
      ua = a; ub = b;
      sa = a[7] ? ua - 256 : ua;
      sb = b[7] ? ub - 256 : ub;
      r.c = 0; r.v = 0; r.e = 0;
      case (op)
         6'h20: begin x = ua + ub; r.c = (x > 255); r.v = (sa + sb > 127) || (sa + sb < -128); end
         6'h22: begin x = ua - ub; r.c = (ua < ub); r.v = (sa - sb > 127) || (sa - sb < -128); end
         6'h24: x = ua & ub;
         6'h25: x = ua | ub;
         6'h26: x = ua ^ ub;
         6'h27: x = ~(ua | ub);
         6'h02: x = (ub >= 8) ? 0 : (ua >> ub);
         6'h03: x = sa >>> ((ub >= 8) ? 7 : ub);
         default: begin x = 0; r.e = 1; end
      endcase
      r.res = x[7:0];
      r.z = (r.res == 8'h00);
      return r;
   endfunction

   function automatic void model_step(input logic [2:0] mask, input logic [7:0] s);
      logic [2:0] rise;
      logic       err;
      ev_t        ev;
      res_t       r;
      rise = mask & ~mprev;
      mprev = mask;
      err = 0;
      if (mstate == 3) begin
         r = model_alu(ma, mb, mop);
         res_q.push_back(r);
         mres = r.res;
         mstate = 4;
         err = (rise != 0);
      end else if ($countones(rise) > 1) begin
         err = 1;
      end else if (rise == 3'b001 && (mstate == 0 || mstate == 4)) begin
         ma = s; mstate = 1;
      end else if (rise == 3'b010 && mstate == 1) begin
         mb = s; mstate = 2;
      end else if (rise == 3'b010 && mstate == 4 && Chain) begin
         ma = mres; mb = s; mstate = 2;
      end else if (rise == 3'b100 && mstate == 2) begin
         mop = s[5:0]; mstate = 3;
      end else if (rise != 0) begin
         err = 1;
      end
      ev.cyc = cyc + 1; ev.err = err; ev.st = mstate[2:0];
      ev_q.push_back(ev);
   endfunction

   task automatic cycle(input logic [2:0] mask, input logic [7:0] s);
      @(negedge clk);
      rst_n = 1'b1; btn = mask; sw = s;
      model_step(mask, s);
   endtask

   task automatic press(input logic [2:0] mask, input logic [7:0] s);
      cycle(mask, s);
      cycle(3'b000, s);
   endtask

   task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
      press(3'b001, a);
      press(3'b010, b);
      press(3'b100, {2'b00, op});
      cycle(3'b000, 8'h00);
   endtask

   task automatic do_reset(input logic [2:0] held);
      ev_t ev;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         rst_n = 1'b0; btn = held;
         mstate = 0; ma = '0; mb = '0; mop = '0; mres = '0; mprev = held;
         ev.cyc = cyc + 1; ev.err = 0; ev.st = 3'd0;
         ev_q.push_back(ev);
      end
      @(posedge clk); #1;
      check("rst_result", {24'h0, result}, 32'h0);
      check("rst_flags", {26'h0, valid, zero, carry, ovf, op_err, seq_err}, 32'h0);
   endtask

   // Monitor: per-cycle state/error events, and result records on each rising o_valid.
   initial begin
      logic prev_vld;
      res_t r;
      prev_vld = 1'b0;
      forever begin
         @(negedge clk);
         if (ev_q.size() > 0 && ev_q[0].cyc == cyc) begin
            ev_t e;
            e = ev_q.pop_front();
            check("seq_err", {31'h0, seq_err}, {31'h0, e.err});
            check("state", {29'h0, state}, {29'h0, e.st});
         end
         if (valid && !prev_vld) begin
            if (res_q.size() == 0) begin
               check("unexpected_valid", 32'h1, 32'h0);
            end else begin
               r = res_q.pop_front();
               check("result", {24'h0, result}, {24'h0, r.res});
               check("flags_zcvE", {28'h0, zero, carry, ovf, op_err}, {28'h0, r.z, r.c, r.v, r.e});
            end
         end
         prev_vld = valid;
      end
   end

   initial begin
      logic [5:0] ops[8];
      logic [5:0] op;
      logic [7:0] b;
      int         sel;
      ops = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h02, 6'h03};

      do_reset(3'b000);
      do_op(8'h7F, 8'h01, 6'h20);
      do_op(8'h00, 8'h01, 6'h22);
      do_op(8'h80, 8'h01, 6'h22);
      do_op(8'h80, 8'h03, 6'h02);
      do_op(8'h80, 8'h09, 6'h03);
      do_op(8'h80, 8'h09, 6'h02);

      do_reset(3'b000);
      press(3'b100, 8'h00);
      press(3'b011, 8'h00);

      do_op(8'h12, 8'h34, 6'h3F);
      do_op(8'hFF, 8'h01, 6'h20);

      // Reset while in HAVE_B with button 1 held through release.
      press(3'b001, 8'h11);
      press(3'b010, 8'h22);
      do_reset(3'b010);
      cycle(3'b010, 8'h33);
      cycle(3'b010, 8'h33);
      press(3'b000, 8'h00);
      press(3'b010, 8'h44);

      // Chain attempt from DONE; result depends on ALU_CHAIN_EN.
      do_op(8'h02, 8'h03, 6'h20);
      press(3'b010, 8'h03);
      press(3'b100, 8'h20);
      cycle(3'b000, 8'h00);

      // Button pressed during EXEC is rejected.
      press(3'b001, 8'h05);
      press(3'b010, 8'h06);
      cycle(3'b100, 8'h26);
      cycle(3'b001, 8'h77);
      cycle(3'b000, 8'h00);

      for (int i = 0; i < 250; i++) begin
         sel = $urandom_range(0, 9);
         b = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 10)) : 8'($urandom);
         op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 7)];
         if (sel < 6) do_op(8'($urandom), b, op);
         else if (sel < 8) press(3'(1 << $urandom_range(0, 2)), 8'($urandom));
         else cycle(3'($urandom_range(0, 7)), 8'($urandom));
         if (i == 120) do_reset(3'($urandom_range(0, 7)));
      end

      for (int i = 0; i < 4; i++) cycle(3'b000, 8'h00);
      @(negedge clk);
      check("res_q_drained", res_q.size(), 32'h0);
      check("ev_q_drained", ev_q.size(), 32'h0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
